forwarding_scoreboard: RTL

- Parametrised successor to the single-port operand forwarder: tracks in-flight register writes internally in a STAGES-deep shift structure instead of taking pipeline status as an input.
- Serves READ_PORTS operand read ports in parallel.
- Supports late result fills (e.g. load data) and flush.
- Emits the retiring write toward the register file and counts stall cycles.
- Sits between decode, which reads the ports, and the execute/memory/writeback stages, which push, fill and retire.

---
 rtl/forwarding_scoreboard.sv | 125 ++++++++++++
 1 files changed

// File: rtl/forwarding_scoreboard.sv
// Operand forwarding scoreboard: tracks in-flight writes in a shift structure,
// forwards to several read ports, accepts late fills and retires the oldest.
module forwarding_scoreboard #(
  parameter int READ_PORTS = 2,
  parameter int STAGES     = 3,
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 5,
  parameter int CNT_W      = 32,
  localparam int FS_W = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         advance,
  input  logic                         flush,
  input  logic                         push_valid,
  input  logic [ADDR_W-1:0]            push_address,
  input  logic [XLEN-1:0]              push_data,
  input  logic                         push_data_valid,
  input  logic                         fill_valid,
  input  logic [FS_W-1:0]              fill_stage,
  input  logic [XLEN-1:0]              fill_data,
  input  logic [READ_PORTS*ADDR_W-1:0] read_address,
  input  logic [READ_PORTS*XLEN-1:0]   register_file_data,
  output logic [READ_PORTS*XLEN-1:0]   data,
  output logic [READ_PORTS-1:0]        port_stall,
  output logic                         stall,
  output logic                         retire_valid,
  output logic [ADDR_W-1:0]            retire_address,
  output logic [XLEN-1:0]              retire_data,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] occ_q, occ_d;
  logic [STAGES-1:0] dv_q, dv_d;
  logic [ADDR_W-1:0] addr_q [STAGES];
  logic [ADDR_W-1:0] addr_d [STAGES];
  logic [XLEN-1:0]   data_q [STAGES];
  logic [XLEN-1:0]   data_d [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fill_hit;
  logic              retire_fill;

  assign fill_hit = fill_valid
                  && (int'(fill_stage) < STAGES)
                  && occ_q[fill_stage];

  // A fill to a moving entry lands one index further down.
  always_comb begin
    occ_d  = occ_q;
    dv_d   = dv_q;
    addr_d = addr_q;
    data_d = data_q;
    if (flush) begin
      occ_d = '0;
    end else if (advance) begin
      for (int i = STAGES - 1; i >= 1; i--) begin
        occ_d[i]  = occ_q[i-1];
        dv_d[i]   = dv_q[i-1];
        addr_d[i] = addr_q[i-1];
        data_d[i] = data_q[i-1];
      end
      occ_d[0]  = push_valid;
      dv_d[0]   = push_data_valid;
      addr_d[0] = push_address;
      data_d[0] = push_data;
      for (int i = 0; i < LAST; i++) begin
        if (fill_hit && fill_stage == FS_W'(i)) begin
          data_d[i+1] = fill_data;
          dv_d[i+1]   = 1'b1;
        end
      end
    end else if (fill_hit) begin
      data_d[fill_stage] = fill_data;
      dv_d[fill_stage]   = 1'b1;
    end
  end

  assign retire_fill    = advance && fill_hit
                        && (fill_stage == FS_W'(LAST));
  assign retire_valid   = advance && occ_q[LAST]
                        && (addr_q[LAST] != '0);
  assign retire_address = addr_q[LAST];
  assign retire_data    = retire_fill ? fill_data : data_q[LAST];

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    data       = register_file_data;
    port_stall = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (occ_q[i]
            && addr_q[i] != '0
            && addr_q[i] == read_address[p*ADDR_W +: ADDR_W]) begin
          data[p*XLEN +: XLEN] = data_q[i];
          port_stall[p]        = ~dv_q[i];
        end
      end
    end
  end

  assign stall        = |port_stall;
  assign cnt_d        = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  assign stall_cycles = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      dv_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      occ_q  <= occ_d;
      dv_q   <= dv_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

endmodule
